// File: rtl/pipe_pkg.sv
// Shared types and defaults for the IF-stage program-counter logic.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int          PC_W_DEF      = 8;
    localparam int unsigned RESET_VEC_DEF = 32'h0000_0000;
    localparam int unsigned TRAP_VEC_DEF  = 32'h0000_00F0;

    typedef logic [PC_W_DEF-1:0] pc_t;

    // Which source feeds the PC register at the next edge.
    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_REDIR,
        SEL_HOLD,
        SEL_REPL,
        SEL_CALL,
        SEL_RET,
        SEL_SEQ
    } pc_sel_e;

    // Fixed priority: trap > redirect > stall > call+ret > call > ret > sequential.
    function automatic pc_sel_e pick_sel(input logic trap, input logic redirect,
                                         input logic stall, input logic call,
                                         input logic ret);
        pc_sel_e sel;
        if (trap)             sel = SEL_TRAP;
        else if (redirect)    sel = SEL_REDIR;
        else if (stall)       sel = SEL_HOLD;
        else if (call && ret) sel = SEL_REPL;
        else if (call)        sel = SEL_CALL;
        else if (ret)         sel = SEL_RET;
        else                  sel = SEL_SEQ;
        return sel;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push / pop / replace-top, oldest entry overwritten when full.
// Latency: updates visible one cycle after the request; top/empty/full derive from registered state.
// Backpressure: none; push on full overwrites, pop on empty raises a one-cycle underflow pulse.
module ras_stack
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = PC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         replace,
    input  logic [W-1:0] push_dat,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_inc;
    logic [CNT_W-1:0] cnt;
    logic             do_push;
    logic             do_repl;
    logic             do_pop;

    // Replace on an empty stack degenerates into a plain push.
    always_comb begin
        ptr_inc = ptr + PTR_W'(1);
        do_repl = replace & ~empty;
        do_push = push | (replace & empty);
        do_pop  = pop & ~empty & ~replace & ~push;
        top     = mem[ptr];
        empty   = (cnt == '0);
        full    = (cnt == CNT_W'(DEPTH));
    end

    // Pointer, occupancy, entries and the underflow pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            cnt       <= '0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            underflow <= pop & empty & ~replace & ~push;
            if (do_repl) begin
                mem[ptr] <= push_dat;
            end else if (do_push) begin
                mem[ptr_inc] <= push_dat;
                ptr          <= ptr_inc;
                if (!full) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (do_pop) begin
                ptr <= ptr - PTR_W'(1);
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch address generator with stall, redirect, trap and RAS call/return prediction.
// Latency: pc updates one cycle after the inputs; pc_next shows that value combinationally.
// Backpressure: stall holds pc and suppresses call/ret; trap and redirect override stall.
module pc_gen
    import pipe_pkg::*;
#(
    parameter int          PC_W      = PC_W_DEF,
    parameter int unsigned INC       = 1,
    parameter int unsigned RESET_VEC = RESET_VEC_DEF,
    parameter int unsigned TRAP_VEC  = TRAP_VEC_DEF,
    parameter int          RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_target,
    input  logic            call,
    input  logic [PC_W-1:0] call_target,
    input  logic            ret,
    input  logic            trap,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_next,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_underflow
);

    localparam logic [PC_W-1:0] RST_PC  = PC_W'(RESET_VEC);
    localparam logic [PC_W-1:0] TRAP_PC = PC_W'(TRAP_VEC);
    localparam logic [PC_W-1:0] STEP    = PC_W'(INC);

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_seq;
    logic [PC_W-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_repl;

    // Priority decode and next-PC mux; a ret on an empty stack falls through to sequential.
    always_comb begin
        sel      = pick_sel(trap, redirect, stall, call, ret);
        pc_seq   = pc + STEP;
        ras_push = (sel == SEL_CALL);
        ras_pop  = (sel == SEL_RET);
        ras_repl = (sel == SEL_REPL);
        pc_next  = pc_seq;
        case (sel)
            SEL_TRAP:  pc_next = TRAP_PC;
            SEL_REDIR: pc_next = redirect_target;
            SEL_HOLD:  pc_next = pc;
            SEL_REPL:  pc_next = call_target;
            SEL_CALL:  pc_next = call_target;
            SEL_RET:   pc_next = ras_empty ? pc_seq : ras_top;
            default:   pc_next = pc_seq;
        endcase
    end

    // PC register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RST_PC;
        end else begin
            pc <= pc_next;
        end
    end

    ras_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .replace   (ras_repl),
        .push_dat  (pc_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .underflow (ras_underflow)
    );

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the 5-stage pipeline's IF stage. It supplies the fetch address every cycle and supports stall, EX-stage redirect (branch/jump), a trap vector, and call/return prediction through a small circular return-address stack (RAS). It replaces the fixed 8-bit increment/jump PC and sits between the hazard unit, the EX stage and instruction memory.

Parameters:
PC_W, 8, PC width in bits; all PC arithmetic is modulo 2^PC_W.
INC, 1, sequential increment (word-addressed instruction memory).
RESET_VEC, 0, PC value loaded on reset.
TRAP_VEC, 8'hF0, PC value loaded on trap; truncated/zero-extended to PC_W.
RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard unit: hold PC (IF stage frozen)
redirect  in  1  EX stage: branch taken or jump resolved
redirect_target  in  PC_W  redirect destination
call  in  1  decoded call in IF: push return address and jump
call_target  in  PC_W  call destination
ret  in  1  decoded return in IF: pop and jump
trap  in  1  exception/trap request
pc  out  PC_W  current fetch address
pc_next  out  PC_W  combinational value pc will take at the next edge
ras_empty  out  1  RAS holds 0 valid entries
ras_full  out  1  RAS holds RAS_DEPTH valid entries
ras_underflow  out  1  registered one-cycle pulse: ret with RAS empty

Behaviour:
- Reset (rst=0, asynchronous): pc=RESET_VEC, RAS count=0, top pointer=0, ras_underflow=0, ras_empty=1, ras_full=0. Entry contents are don't-care.
- pc is registered; pc_next is combinational from the current inputs and state, so each update has 1-cycle latency.
- Priority, evaluated each edge with rst=1, highest first:
  1. trap: pc<=TRAP_VEC. Overrides stall. RAS unchanged.
  2. redirect: pc<=redirect_target. Overrides stall. RAS unchanged; any call/ret in the same cycle is squashed.
  3. stall: pc holds. call/ret are ignored, with no RAS change and no underflow pulse.
  4. call and ret together: replace the top entry (pop then push). Top entry<=pc+INC, count unchanged, pc<=call_target. If the RAS is empty, this acts as a plain call.
  5. call: push pc+INC and set pc<=call_target.
     - Not full: top pointer advances and count increments.
     - Full: the pointer advances circularly, overwriting the oldest entry, and count stays at RAS_DEPTH (no error).
  6. ret: count>0 pops, pc<=top entry, top pointer retreats circularly, count decrements. Count=0 gives pc<=pc+INC and ras_underflow=1 on the next cycle only.
  7. Otherwise: pc<=pc+INC.
- Wrap-around: pc+INC at all-ones wraps to low addresses with no flag. Pushed return addresses also wrap.
- ras_underflow is cleared on every edge where it was not freshly set.
- ras_empty = (count==0). ras_full = (count==RAS_DEPTH). Both are derived combinationally from registered count.
- Reset asserted mid-operation takes effect immediately, regardless of clk, and discards all RAS state.
- X-safety: control inputs are sampled only when rst=1. No latches. Single always_ff block for state; next-state logic is combinational.

Decomposition:
- Shared package pipe_pkg: the PC_W default, the RESET_VEC/TRAP_VEC defaults, and a pc_t typedef (logic [PC_W-1:0]).
- One sub-module, ras_stack, is natural. It is a circular LIFO of RAS_DEPTH x PC_W with push/pop/replace inputs and top/empty/full/underflow outputs, sharing clk/rst.
- pc_gen holds the PC register and the priority mux.

Test Plan:
1. Reset then 3 free-running cycles -> pc 0,1,2,3; ras_empty=1; with rst pulled low mid-cycle, pc=0 immediately, without waiting for an edge.
2. At pc=5, assert stall for 2 cycles -> pc stays 5; at pc=5 assert stall+redirect (target 8'h40) -> next pc=8'h40.
3. At pc=10, call with call_target=8'h80 -> pc=8'h80 and RAS top=11; after 2 sequential cycles, ret -> pc=11 and ras_empty=1.
4. RAS_DEPTH=4, 5 nested calls from pc 1,3,5,7,9 -> ras_full=1; 4 rets return 10,8,6,4 in that order; a 5th ret -> pc=pc+1 and a one-cycle ras_underflow pulse.
5. Same cycle trap+redirect+call at pc=20 -> pc=8'hF0 and RAS count unchanged; redirect+ret with 1 entry -> pc=redirect_target and the entry is preserved.
6. PC_W=8, pc=8'hFF sequential -> pc=8'h00; call at pc=8'hFF pushes 8'h00, and a later ret -> pc=8'h00.
